framebuffer_streamer: RTL and testbench
=======================================

Name: framebuffer_streamer

Overview:
- Upstream feeder of the SPI display controller.
- On a start request it reads one full frame of RGB pixels from framebuffer RAM, which has fixed read latency, and emits them as a 16-bit AXI Stream with tlast on the final pixel.
- Drives the controller's start handshake and absorbs downstream backpressure with a credit-limited holding FIFO.

Parameters:
- PIXEL, 16384, pixels per frame; beats per stream.
- MEM_LATENCY, 1, cycles from mem_rd high to valid mem_data (range 1..4).
- FIFO_DEPTH, MEM_LATENCY+2, holding FIFO entries; also the read-credit limit.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame request.
- busy  out  1  high while a frame is being fetched or streamed.
- done  out  1  one-cycle pulse after the last beat is accepted.
- mem_rd  out  1  framebuffer read strobe.
- mem_addr  out  $clog2(PIXEL)  framebuffer read address.
- mem_data  in  16  read data, valid exactly MEM_LATENCY cycles after mem_rd.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on beat PIXEL-1 only.
- m_axis_tdata  out  16  pixel.
- startTransfer  out  1  request to the display controller.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it takes effect immediately, without waiting for a clk edge.
- Reset values: busy, done, mem_rd, m_axis_tvalid, m_axis_tlast and startTransfer = 0; mem_addr = 0; m_axis_tdata = 0; FIFO empty; all counters 0; state IDLE.
- Reset mid-frame aborts the frame. In-flight reads are discarded, and no beat is emitted after reset deasserts until a new start.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - start=1 -> STREAM.
  - On that transition: issueCnt=0, beatCnt=0, busy=1, startTransfer=1.
  - start while not IDLE is ignored.
- STREAM, read side:
  - mem_rd=1 in a cycle when issueCnt<PIXEL and (inflight + fifoCount) < FIFO_DEPTH.
  - On each read: mem_addr = issueCnt and issueCnt increments.
  - inflight counts reads whose data has not yet landed.
  - Returning data is written into the FIFO exactly MEM_LATENCY cycles after its mem_rd. A MEM_LATENCY-deep valid shift register tracks this.
- STREAM, output side:
  - m_axis_tvalid = FIFO not empty; m_axis_tdata = FIFO head (registered / first-word-fall-through).
  - A beat transfers when tvalid && tready; the FIFO then pops and beatCnt increments.
  - While tvalid=1 and tready=0, tdata and tlast hold stable.
  - m_axis_tlast = (beatCnt == PIXEL-1) && tvalid.
- Simultaneous push and pop in one cycle leaves fifoCount unchanged. The credit check uses the pre-cycle counts, so the FIFO never overflows.
- Throughput: with tready held at 1, one beat per cycle after the initial MEM_LATENCY+1 cycles.
- startTransfer: held at 1 from STREAM entry until the first beat is accepted, then 0.
- Last beat accepted -> FINISH. In FINISH: done=1 for one cycle, busy=0, next state IDLE.
- Counter widths: $clog2(PIXEL)+1 bits, so the value PIXEL is representable. No wrap-around occurs within a frame.

Optional Feature:
- Macro: FRAMEBUFFER_STREAMER_ROTATE180_EN.
- Defined: mem_addr = PIXEL-1-issueCnt, so the frame is streamed in reverse order (display rotated 180°). tlast is still asserted on beat PIXEL-1.
- Undefined: mem_addr = issueCnt (ascending order).
- Handshake, latency and counts are identical in both builds.

Test Plan:
- PIXEL=16, MEM_LATENCY=1, tready=1, mem[i]=i*0x111, start pulse -> 16 consecutive beats with tdata=i*0x111; tlast only on beat 15; done pulses 1 cycle after beat 15; busy falls at the same time.
- Same setup with tready toggled pseudo-randomly (50%) -> exactly 16 beats, in order, none lost or duplicated; tdata/tlast stable whenever tvalid=1 and tready=0.
- MEM_LATENCY=3, tready held 0 for 20 cycles after start -> exactly FIFO_DEPTH=5 mem_rd pulses, then mem_rd stays 0; after tready=1 all 16 beats arrive in order.
- A second start at beat 5 -> ignored; frame completes with 16 beats and a single done pulse.
- reset asserted asynchronously between edges at beat 7 -> outputs take reset values immediately; a new start streams from mem[0] with a full 16 beats.
- Build with FRAMEBUFFER_STREAMER_ROTATE180_EN: first beat = mem[15], last beat (tlast) = mem[0]; mem_addr sequence runs 15..0.

Source files
------------

// File: rtl/framebuffer_streamer.sv
// framebuffer_streamer: reads one frame from fixed-latency RAM and emits it as a 16-bit AXI Stream.
// Optional: define FRAMEBUFFER_STREAMER_ROTATE180_EN to fetch the frame in descending address order.
module framebuffer_streamer #(
    parameter int PIXEL       = 16384,
    parameter int MEM_LATENCY = 1,
    parameter int FIFO_DEPTH  = MEM_LATENCY + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd,
    output logic [$clog2(PIXEL)-1:0] mem_addr,
    input  logic [15:0]              mem_data,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [15:0]              m_axis_tdata,
    output logic                     startTransfer
);
    localparam int AW = $clog2(PIXEL);
    localparam int CW = AW + 1;
    localparam int QW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] PIX_C   = CW'(PIXEL);
    localparam logic [CW-1:0] LAST_C  = CW'(PIXEL - 1);
    localparam logic [QW:0]   DEPTH_C = (QW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                 state_q;
    logic [CW-1:0]          issue_cnt_q;
    logic [CW-1:0]          beat_cnt_q;
    logic [QW-1:0]          inflight_q, inflight_d;
    logic [QW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [15:0]            fifo_q [FIFO_DEPTH];
    logic [MEM_LATENCY-1:0] vld_sr_q;
    logic                   busy_q, done_q, start_xfer_q;
    logic [AW-1:0]          addr_d;
    logic                   push, pop, issue;

    // Credit covers reads still in the RAM pipeline plus words held in the FIFO.
    assign issue = (state_q == STREAM) && (issue_cnt_q < PIX_C)
                && (({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
    assign push  = vld_sr_q[MEM_LATENCY-1];
    assign pop   = m_axis_tvalid && m_axis_tready;

`ifdef FRAMEBUFFER_STREAMER_ROTATE180_EN
    assign addr_d = AW'(LAST_C - issue_cnt_q);
`else
    assign addr_d = issue_cnt_q[AW-1:0];
`endif

    assign mem_rd        = issue;
    assign mem_addr      = issue ? addr_d : '0;
    assign m_axis_tvalid = (fifo_cnt_q != '0);
    assign m_axis_tdata  = fifo_q[rd_ptr_q];
    assign m_axis_tlast  = (beat_cnt_q == LAST_C) && m_axis_tvalid;
    assign busy          = busy_q;
    assign done          = done_q;
    assign startTransfer = start_xfer_q;

    always_comb begin
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        if (issue && !push) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && push) begin
            inflight_d = inflight_q - 1'b1;
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    generate
        if (MEM_LATENCY == 1) begin : g_sr1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) vld_sr_q <= '0;
                else       vld_sr_q <= issue;
            end
        end else begin : g_srn
            always_ff @(posedge clk or posedge reset) begin
                if (reset) vld_sr_q <= '0;
                else       vld_sr_q <= {vld_sr_q[MEM_LATENCY-2:0], issue};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_data;
                wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            inflight_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_xfer_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= inflight_d;
            if (issue) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (pop)   beat_cnt_q  <= beat_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= STREAM;
                        issue_cnt_q  <= '0;
                        beat_cnt_q   <= '0;
                        busy_q       <= 1'b1;
                        start_xfer_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pop) start_xfer_q <= 1'b0;
                    if (pop && (beat_cnt_q == LAST_C)) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_streamer.sv
// tb_framebuffer_streamer: two instances (latency 1 and 3) share stimulus; a frame-order
// reference model checks every beat, handshake, read address and credit bound.
module tb_framebuffer_streamer;
    localparam int PIX = 16;
`ifdef FRAMEBUFFER_STREAMER_ROTATE180_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        int pat;
        int pct;
        int hold;
        int span;
        int rd0;
        int rd1;
        int beats;
        int dones;
    } vec_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start  = 1'b0;
    logic tready = 1'b0;
    logic [1:0]       busy, done, rd, tvalid, tlast, stx;
    logic [1:0][3:0]  addr;
    logic [1:0][15:0] tdata, mdata;

    logic [15:0]      memv [PIX];
    logic [1:0]       rq_s = '0;
    logic [1:0][3:0]  ra_s = '0;
    logic [15:0]      p1   = '0;
    logic [15:0]      p3 [3] = '{default: '0};

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   act [2];
    bit   fin [2];
    bit   pv  [2];
    int   cnt [2];
    int   rd_n [2];
    int   dcount [2];
    int   dc0 [2];
    int   first_acc [2];
    int   last_acc [2];
    logic [15:0] pdata [2];
    logic plast [2];
    bit   acc, fin_n;

    always #5 clk = ~clk;

    framebuffer_streamer #(.PIXEL(PIX), .MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
        .mem_rd(rd[0]), .mem_addr(addr[0]), .mem_data(mdata[0]),
        .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready), .m_axis_tlast(tlast[0]),
        .m_axis_tdata(tdata[0]), .startTransfer(stx[0])
    );

    framebuffer_streamer #(.PIXEL(PIX), .MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
        .mem_rd(rd[1]), .mem_addr(addr[1]), .mem_data(mdata[1]),
        .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready), .m_axis_tlast(tlast[1]),
        .m_axis_tdata(tdata[1]), .startTransfer(stx[1])
    );

    // Framebuffer RAMs: request sampled mid-cycle, data valid LAT cycles after mem_rd.
    always @(negedge clk) begin
        rq_s <= rd;
        ra_s <= addr;
    end

    always @(posedge clk) begin
        p1    <= rq_s[0] ? memv[ra_s[0]] : 16'hDEAD;
        p3[0] <= rq_s[1] ? memv[ra_s[1]] : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign mdata[0] = p1;
    assign mdata[1] = p3[2];

    function automatic int ord(input int k);
        return ROT ? PIX - 1 - k : k;
    endfunction

    function automatic int depth(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    function automatic logic rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic chk(input string nm, input int i, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, i, act_v, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i]  = 1'b0;
                fin[i]  = 1'b0;
                pv[i]   = 1'b0;
                cnt[i]  = 0;
                rd_n[i] = 0;
            end else begin
                acc = tvalid[i] && tready;
                if (done[i]) dcount[i]++;
                chk("busy", i, busy[i], act[i]);
                chk("done", i, done[i], fin[i]);
                chk("startTransfer", i, stx[i], int'(act[i] && cnt[i] == 0));
                if (!act[i]) chk("tvalid_idle", i, tvalid[i], 0);
                chk("tlast", i, tlast[i], int'(tvalid[i] && cnt[i] == PIX - 1));
                if (pv[i]) begin
                    chk("hold_valid", i, tvalid[i], 1);
                    chk("hold_data", i, tdata[i], pdata[i]);
                    chk("hold_last", i, tlast[i], plast[i]);
                end
                if (acc) begin
                    chk("beat_range", i, int'(cnt[i] < PIX), 1);
                    if (cnt[i] < PIX) chk("tdata", i, tdata[i], memv[ord(cnt[i])]);
                end
                if (rd[i]) begin
                    chk("rd_range", i, int'(rd_n[i] < PIX), 1);
                    chk("mem_addr", i, addr[i], ord(rd_n[i]));
                    chk("credit", i, int'(rd_n[i] + 1 - cnt[i] <= depth(i)), 1);
                    rd_n[i]++;
                end
                pv[i]    = tvalid[i] && !tready;
                pdata[i] = tdata[i];
                plast[i] = tlast[i];
                fin_n    = 1'b0;
                if (act[i]) begin
                    if (acc) begin
                        if (cnt[i] == 0) first_acc[i] = cyc;
                        last_acc[i] = cyc;
                        cnt[i]++;
                        if (cnt[i] == PIX) begin
                            act[i] = 1'b0;
                            fin_n  = 1'b1;
                        end
                    end
                end else if (!fin[i] && start) begin
                    act[i]  = 1'b1;
                    cnt[i]  = 0;
                    rd_n[i] = 0;
                end
                fin[i] = fin_n;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < PIX; k++) begin
            memv[k] = (pat == 0) ? 16'(k * 16'h111) : 16'($urandom);
        end
    endtask

    task automatic start_frame();
        dc0[0] = dcount[0];
        dc0[1] = dcount[1];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int pct);
        int ok;
        ok = 0;
        for (int c = 0; c < 800 && ok == 0; c++) begin
            tready = rnd(pct);
            step();
            ok = int'(!act[0] && !act[1] && !fin[0] && !fin[1]);
        end
        chk("frame_complete", 0, ok, 1);
    endtask

    task automatic wait_beat(input int n);
        int ok;
        ok = 0;
        for (int c = 0; c < 400 && ok == 0; c++) begin
            tready = 1'b1;
            step();
            ok = int'(cnt[0] >= n);
        end
        chk("reach_beat", 0, ok, 1);
    endtask

    task automatic check_frame(input int beats, input int dones, input int span);
        for (int i = 0; i < 2; i++) begin
            chk("frame_beats", i, cnt[i], beats);
            chk("done_pulses", i, dcount[i] - dc0[i], dones);
            if (span >= 0) chk("throughput_span", i, last_acc[i] - first_acc[i], span);
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, busy[i], 0);
            chk("rst_done", i, done[i], 0);
            chk("rst_mem_rd", i, rd[i], 0);
            chk("rst_mem_addr", i, addr[i], 0);
            chk("rst_tvalid", i, tvalid[i], 0);
            chk("rst_tlast", i, tlast[i], 0);
            chk("rst_tdata", i, tdata[i], 0);
            chk("rst_startTransfer", i, stx[i], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        vt[0] = '{0, 100,  0, 15, -1, -1, PIX, 1};
        vt[1] = '{0,  50,  0, -1, -1, -1, PIX, 1};
        vt[2] = '{1, 100, 20, -1,  3,  5, PIX, 1};
        vt[3] = '{1,  30,  0, -1, -1, -1, PIX, 1};
        vt[4] = '{1, 100,  0, 15, -1, -1, PIX, 1};
        vt[5] = '{1,  75,  5, -1, -1, -1, PIX, 1};

        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        reset = 1'b0;
        step();
        step();

        for (int v = 0; v < 6; v++) begin
            fill(vt[v].pat);
            start_frame();
            for (int c = 0; c < vt[v].hold; c++) begin
                tready = 1'b0;
                step();
            end
            if (vt[v].rd0 >= 0) begin
                chk("hold_reads", 0, rd_n[0], vt[v].rd0);
                chk("hold_reads", 1, rd_n[1], vt[v].rd1);
            end
            wait_idle(vt[v].pct);
            check_frame(vt[v].beats, vt[v].dones, vt[v].span);
            step();
        end

        // Second start mid-frame must be ignored.
        fill(1);
        start_frame();
        wait_beat(5);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(60);
        check_frame(PIX, 1, -1);
        repeat (4) step();

        // Asynchronous reset mid-frame aborts; next frame restarts from the beginning.
        fill(0);
        start_frame();
        wait_beat(7);
        #2;
        reset = 1'b1;
        #1;
        check_reset();
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tready = 1'b1;
            step();
        end
        chk("no_beats_after_reset", 0, cnt[0], 0);
        chk("no_beats_after_reset", 1, cnt[1], 0);
        start_frame();
        wait_idle(100);
        check_frame(PIX, 1, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
